// File: rtl/dcache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dcache_pkg
// Brief   : Shared geometry, FSM state encoding and byte-select helper.
// Revision: 1.0
// ============================================================================
package dcache_pkg;
  localparam int NUM_BLOCKS  = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int ADDR_W      = 8;
  localparam int INDEX_W     = $clog2(NUM_BLOCKS);
  localparam int OFFSET_W    = $clog2(BLOCK_BYTES);
  localparam int TAG_W       = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINE_W      = 8 * BLOCK_BYTES;
  localparam int MEM_ADDR_W  = TAG_W + INDEX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2,
    UPDATE    = 2'd3
  } state_t;

  function automatic logic [7:0] get_byte(input logic [LINE_W-1:0] line,
                                          input logic [OFFSET_W-1:0] off);
    return line[{off, 3'b000} +: 8];
  endfunction
endpackage
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
// Module  : dcache_array
// Brief   : Data/tag/valid/dirty storage; async read, sync byte write and line fill.
// Revision: 1.0
// ============================================================================
module dcache_array
  import dcache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  i_rd_index,
  output logic [LINE_W-1:0]   o_rd_line,
  output logic [TAG_W-1:0]    o_rd_tag,
  output logic                o_rd_valid,
  output logic                o_rd_dirty,
  input  logic                i_wr_en,
  input  logic [INDEX_W-1:0]  i_wr_index,
  input  logic [OFFSET_W-1:0] i_wr_offset,
  input  logic [7:0]          i_wr_byte,
  input  logic                i_fill_en,
  input  logic [INDEX_W-1:0]  i_fill_index,
  input  logic [TAG_W-1:0]    i_fill_tag,
  input  logic [LINE_W-1:0]   i_fill_line
);
  logic [LINE_W-1:0]     r_data [NUM_BLOCKS];
  logic [TAG_W-1:0]      r_tag  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] r_valid;
  logic [NUM_BLOCKS-1:0] r_dirty;

  assign o_rd_line  = r_data[i_rd_index];
  assign o_rd_tag   = r_tag[i_rd_index];
  assign o_rd_valid = r_valid[i_rd_index];
  assign o_rd_dirty = r_dirty[i_rd_index];

  // Only the status bits are reset; data and tags are meaningless while invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_en) begin
      r_valid[i_fill_index] <= 1'b1;
      r_dirty[i_fill_index] <= 1'b0;
    end else if (i_wr_en) begin
      r_dirty[i_wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_fill_en) begin
      r_data[i_fill_index] <= i_fill_line;
      r_tag[i_fill_index]  <= i_fill_tag;
    end else if (i_wr_en) begin
      r_data[i_wr_index][{i_wr_offset, 3'b000} +: 8] <= i_wr_byte;
    end
  end
endmodule
`default_nettype wire

// File: rtl/data_cache.sv
`default_nettype none
// ============================================================================
// Module  : data_cache
// Brief   : Direct-mapped write-back/write-allocate data cache with miss FSM.
// Revision: 1.0
// ============================================================================
module data_cache
  import dcache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_W-1:0]     ADDRESS,
  input  logic [7:0]            WRITEDATA,
  output logic [7:0]            READDATA,
  output logic                  BUSYWAIT,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [MEM_ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0]     mem_writedata,
  input  logic [LINE_W-1:0]     mem_readdata,
  input  logic                  mem_busywait
);
  state_t              r_state;
  state_t              w_next_state;
  logic                r_mem_read;
  logic                r_mem_write;
  logic [LINE_W-1:0]   r_fill_line;

  logic [TAG_W-1:0]    w_tag;
  logic [INDEX_W-1:0]  w_index;
  logic [OFFSET_W-1:0] w_offset;
  logic [LINE_W-1:0]   w_line;
  logic [TAG_W-1:0]    w_line_tag;
  logic                w_valid;
  logic                w_dirty;
  logic                w_hit;
  logic                w_req;
  logic                w_idle;

  assign w_tag    = ADDRESS[ADDR_W-1 -: TAG_W];
  assign w_index  = ADDRESS[OFFSET_W +: INDEX_W];
  assign w_offset = ADDRESS[OFFSET_W-1:0];
  assign w_hit    = w_valid && (w_line_tag == w_tag);
  assign w_req    = READ || WRITE;
  assign w_idle   = (r_state == IDLE);

  dcache_array u_array (
    .clk          (CLK),
    .rst_n        (RESET),
    .i_rd_index   (w_index),
    .o_rd_line    (w_line),
    .o_rd_tag     (w_line_tag),
    .o_rd_valid   (w_valid),
    .o_rd_dirty   (w_dirty),
    .i_wr_en      (w_idle && WRITE && w_hit),
    .i_wr_index   (w_index),
    .i_wr_offset  (w_offset),
    .i_wr_byte    (WRITEDATA),
    .i_fill_en    (r_state == UPDATE),
    .i_fill_index (w_index),
    .i_fill_tag   (w_tag),
    .i_fill_line  (r_fill_line)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:      if (w_req && !w_hit) w_next_state = (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
      WRITEBACK: if (!mem_busywait) w_next_state = ALLOCATE;
      ALLOCATE:  if (!mem_busywait) w_next_state = UPDATE;
      UPDATE:    w_next_state = IDLE;
      default:   w_next_state = IDLE;
    endcase
  end

  // Memory strobes are flopped from the next state so they never glitch on transitions.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state     <= IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_fill_line <= '0;
    end else begin
      r_state     <= w_next_state;
      r_mem_read  <= (w_next_state == ALLOCATE);
      r_mem_write <= (w_next_state == WRITEBACK);
      if (r_state == ALLOCATE && !mem_busywait)
        r_fill_line <= mem_readdata;
    end
  end

  assign mem_read      = r_mem_read;
  assign mem_write     = r_mem_write;
  assign mem_address   = r_mem_write ? {w_line_tag, w_index} :
                         r_mem_read  ? {w_tag, w_index} : '0;
  assign mem_writedata = r_mem_write ? w_line : '0;

  assign BUSYWAIT = RESET && (!w_idle || (w_req && !w_hit));
  assign READDATA = (w_idle && READ && !WRITE && w_hit) ? get_byte(w_line, w_offset) : 8'h00;
endmodule
`default_nettype wire

// File: tb/tb_data_cache.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_cache
// Brief   : Directed bench with a transaction-level cache model checked every cycle.
// Revision: 1.0
// ============================================================================
module tb_data_cache;
  import dcache_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;

  int checks   = 0;
  int failures = 0;
  int mem_lat  = 2;
  int mem_cnt  = 0;
  logic [31:0] mem_arr [64];

  always #5 CLK = ~CLK;

  data_cache u_dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
  );

  function automatic logic [31:0] init_word(input int i);
    case (i)
      1:       return 32'hDDCCBBAA;
      9:       return 32'h44332211;
      17:      return 32'h88776655;
      default: return 32'hA5A50000 | 32'(i);
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Block memory: busy for mem_lat cycles per request, then completes.
  assign mem_readdata = mem_arr[mem_address];
  assign mem_busywait = (mem_read || mem_write) && (mem_cnt < mem_lat);
  initial begin
    for (int i = 0; i < 64; i++) mem_arr[i] = init_word(i);
    forever begin
      @(posedge CLK);
      if (mem_write && !mem_busywait) mem_arr[mem_address] <= mem_writedata;
      if ((mem_read || mem_write) && mem_busywait) mem_cnt <= mem_cnt + 1;
      else mem_cnt <= 0;
    end
  end

  // Reference model: cache contents plus a queue of expected per-cycle miss behaviour.
  typedef struct packed {
    logic        mr;
    logic        mw;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic        fill;
    logic [2:0]  fidx;
    logic [2:0]  ftag;
    logic [31:0] fline;
  } exp_t;

  exp_t        q [$];
  exp_t        e;
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [2:0]  m_tag   [8];
  logic [31:0] m_line  [8];
  logic [31:0] ref_mem [64];
  logic [2:0]  idx, tg;
  int          off;
  logic        hit;

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0; m_line[i] = '0;
    end
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        check("cmp_rst_busywait", 32'(BUSYWAIT), 0);
        check("cmp_rst_mem_read", 32'(mem_read), 0);
        check("cmp_rst_mem_write", 32'(mem_write), 0);
        q.delete();
        for (int i = 0; i < 8; i++) begin m_valid[i] = 1'b0; m_dirty[i] = 1'b0; end
      end else if (q.size() != 0) begin
        e = q.pop_front();
        check("cmp_miss_busywait", 32'(BUSYWAIT), 1);
        check("cmp_miss_mem_read", 32'(mem_read), 32'(e.mr));
        check("cmp_miss_mem_write", 32'(mem_write), 32'(e.mw));
        if (e.mr || e.mw) check("cmp_mem_address", 32'(mem_address), 32'(e.addr));
        if (e.mw) check("cmp_mem_writedata", mem_writedata, e.wdata);
        if (e.fill) begin
          m_line[e.fidx] = e.fline; m_tag[e.fidx] = e.ftag;
          m_valid[e.fidx] = 1'b1;   m_dirty[e.fidx] = 1'b0;
        end
      end else begin
        tg  = ADDRESS[7:5];
        idx = ADDRESS[4:2];
        off = int'(ADDRESS[1:0]);
        hit = m_valid[idx] && (m_tag[idx] == tg);
        check("cmp_idle_busywait", 32'(BUSYWAIT), 32'((READ || WRITE) && !hit));
        check("cmp_idle_mem_read", 32'(mem_read), 0);
        check("cmp_idle_mem_write", 32'(mem_write), 0);
        if (READ && !WRITE && hit)
          check("cmp_readdata", 32'(READDATA), (m_line[idx] >> (8 * off)) & 32'hFF);
        if (WRITE && hit) begin
          m_line[idx]  = (m_line[idx] & ~(32'hFF << (8 * off))) | (32'(WRITEDATA) << (8 * off));
          m_dirty[idx] = 1'b1;
        end else if ((READ || WRITE) && !hit) begin
          if (m_valid[idx] && m_dirty[idx]) begin
            for (int k = 0; k <= mem_lat; k++) begin
              e = '0; e.mw = 1'b1; e.addr = {m_tag[idx], idx}; e.wdata = m_line[idx];
              q.push_back(e);
            end
            ref_mem[{m_tag[idx], idx}] = m_line[idx];
          end
          for (int k = 0; k <= mem_lat; k++) begin
            e = '0; e.mr = 1'b1; e.addr = {tg, idx};
            q.push_back(e);
          end
          e = '0; e.fill = 1'b1; e.fidx = idx; e.ftag = tg; e.fline = ref_mem[{tg, idx}];
          q.push_back(e);
        end
      end
    end
  end

  task automatic wait_idle(input string name, output int wcnt);
    int n;
    n = 0;
    wcnt = 0;
    while (BUSYWAIT && n < 100) begin
      if (mem_write) wcnt++;
      @(posedge CLK); #1;
      n++;
    end
    check({name, "_timeout"}, 32'(BUSYWAIT), 0);
  endtask

  task automatic step;
    @(posedge CLK); #1;
  endtask

  int w, n;

  initial begin
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    #1 check("reset_busywait", 32'(BUSYWAIT), 0);
    check("reset_mem_read", 32'(mem_read), 0);
    check("reset_mem_write", 32'(mem_write), 0);

    // Cold read miss
    step(); READ = 1'b1; ADDRESS = 8'h04;
    #1 check("t1_busywait", 32'(BUSYWAIT), 1);
    step(); check("t1_mem_read", 32'(mem_read), 1);
    check("t1_mem_address", 32'(mem_address), 32'h01);
    wait_idle("t1", w);
    check("t1_readdata", 32'(READDATA), 32'hAA);

    // Read hit
    #1 ADDRESS = 8'h06;
    #1 check("t2_readdata", 32'(READDATA), 32'hCC);
    check("t2_busywait", 32'(BUSYWAIT), 0);
    check("t2_mem_read", 32'(mem_read), 0);

    // Write hit
    step(); READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h05; WRITEDATA = 8'h55;
    #1 check("t3_busywait", 32'(BUSYWAIT), 0);
    step(); WRITE = 1'b0; READ = 1'b1;
    #1 check("t3_readdata", 32'(READDATA), 32'h55);
    check("t3_dirty1", 32'(u_dut.u_array.r_dirty[1]), 1);

    // Dirty conflict store
    step(); READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h25; WRITEDATA = 8'h77;
    #1 check("t4_busywait", 32'(BUSYWAIT), 1);
    step(); check("t4_mem_write", 32'(mem_write), 1);
    check("t4_wb_address", 32'(mem_address), 32'h01);
    check("t4_wb_data", mem_writedata, 32'hDDCC55AA);
    check("t4_wb_no_read", 32'(mem_read), 0);
    n = 0;
    while (!mem_read && n < 20) begin step(); n++; end
    check("t4_alloc_seen", 32'(mem_read), 1);
    check("t4_alloc_address", 32'(mem_address), 32'h09);
    check("t4_alloc_no_write", 32'(mem_write), 0);
    wait_idle("t4", w);
    check("t4_mem_block1", mem_arr[1], 32'hDDCC55AA);
    step(); WRITE = 1'b0; READ = 1'b1; ADDRESS = 8'h25;
    #1 check("t4_readback", 32'(READDATA), 32'h77);

    // Dirty conflict read with zero-latency memory
    mem_lat = 0;
    step(); ADDRESS = 8'h44;
    #1 wait_idle("t5a", w);
    check("t5a_wb_cycles", 32'(w), 1);
    check("t5a_readdata", 32'(READDATA), 32'h55);
    check("t5a_mem_block9", mem_arr[9], 32'h44337711);

    // Clean conflicts: no writeback
    mem_lat = 3;
    step(); ADDRESS = 8'h04;
    #1 wait_idle("t5b", w);
    check("t5b_no_writeback", 32'(w), 0);
    check("t5b_readdata", 32'(READDATA), 32'hAA);
    step(); ADDRESS = 8'h44;
    #1 wait_idle("t5c", w);
    check("t5c_no_writeback", 32'(w), 0);
    check("t5c_readdata", 32'(READDATA), 32'h55);

    // Reset during allocate
    mem_lat = 2;
    step(); ADDRESS = 8'h08;
    n = 0;
    while (!mem_read && n < 20) begin step(); n++; end
    check("t6_alloc_seen", 32'(mem_read), 1);
    #2 RESET = 1'b0; READ = 1'b0;
    #1 check("t6_mem_read", 32'(mem_read), 0);
    check("t6_busywait", 32'(BUSYWAIT), 0);
    step(); RESET = 1'b1;
    step(); READ = 1'b1; ADDRESS = 8'h04;
    #1 check("t6_miss_after_reset", 32'(BUSYWAIT), 1);
    wait_idle("t6", w);
    check("t6_readdata", 32'(READDATA), 32'hAA);

    step(); READ = 1'b0;
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
